// File: rtl/clk_div_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clk_div_sequencer_if
//  Purpose  : Configuration handshake bundle between a host (control-register
//             block) and the clk_div_sequencer.
//  Signals  : cfg_valid / cfg_ready  request handshake
//             cfg_sel                target channel (0..2, 3 illegal)
//             cfg_div                requested divide factor
//             cfg_done               one-cycle pulse, new factor in effect
//             cfg_err                one-cycle pulse, request rejected
//             busy                   a request is pending
//  Revision : 1.0  initial release
// ============================================================================
interface clk_div_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_done;
    logic             cfg_err;
    logic             busy;

    modport master (
        output cfg_valid, cfg_sel, cfg_div,
        input  cfg_ready, cfg_done, cfg_err, busy
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_div,
        output cfg_ready, cfg_done, cfg_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clk_div_sequencer
//  Purpose  : Three-channel runtime-programmable clock divider. A host writes
//             a new even divide factor for one channel; the update is applied
//             only on that channel's falling-toggle boundary (or immediately
//             if the channel is disabled) so no runt pulse is ever produced.
//  Ports    : clk_in     single clock for all logic
//             reset      synchronous active-high reset
//             en[2:0]    per-channel enable
//             cfg        configuration handshake (slave side)
//             clk_out_1  channel 0 divided clock
//             clk_out_2  channel 1 divided clock
//             clk_out_4  channel 2 divided clock
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_sequencer #(
    parameter int CNT_W         = 16,
    parameter int DEFAULT_DIV_1 = 2,
    parameter int DEFAULT_DIV_2 = 4,
    parameter int DEFAULT_DIV_3 = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [2:0]            en,
    clk_div_sequencer_if.slave    cfg,
    output logic                  clk_out_1,
    output logic                  clk_out_2,
    output logic                  clk_out_4
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_EDGE = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_pend_sel;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_err;

    logic             w_accept;
    logic             w_req_ok;
    logic             w_boundary;
    logic [2:0]       w_hit;
    logic [2:0]       w_out;

    assign w_accept = cfg.cfg_valid && (r_state == c_IDLE);
    assign w_req_ok = (cfg.cfg_sel <= 2'd2) &&
                      (cfg.cfg_div >= CNT_W'(2)) &&
                      !cfg.cfg_div[0];

    // Only the pending target channel can raise a hit; it is meaningful
    // only while waiting for that channel's boundary.
    assign w_boundary = (r_state == c_WAIT_EDGE) && (|w_hit);

    // ------------------------------------------------------------------
    // Configuration sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_pend_sel <= 2'd0;
            r_pend_div <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_req_ok) begin
                            r_pend_sel <= cfg.cfg_sel;
                            r_pend_div <= cfg.cfg_div;
                            r_state    <= c_WAIT_EDGE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_WAIT_EDGE: begin
                    if (w_boundary) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = (r_state == c_IDLE);
    assign cfg.cfg_done  = (r_state == c_DONE);
    assign cfg.cfg_err   = r_err;
    assign cfg.busy      = (r_state != c_IDLE);

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_ch
        localparam logic [CNT_W-1:0] c_DEF_DIV =
            (i == 0) ? CNT_W'(DEFAULT_DIV_1) :
            (i == 1) ? CNT_W'(DEFAULT_DIV_2) :
                       CNT_W'(DEFAULT_DIV_3);

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic             r_out;
        logic [CNT_W-1:0] w_last;
        logic             w_fall;
        logic             w_apply;

        assign w_last = (r_div >> 1) - CNT_W'(1);
        // Output is high and about to toggle low on this edge.
        assign w_fall = r_out && (r_cnt == w_last);
        // A disabled channel is already parked low, so any edge is safe.
        assign w_hit[i] = (r_pend_sel == 2'(i)) && (!en[i] || w_fall);
        assign w_apply  = w_hit[i] && (r_state == c_WAIT_EDGE);

        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_cnt <= '0;
                r_out <= 1'b0;
                r_div <= c_DEF_DIV;
            end else if (w_apply) begin
                // New factor starts with a full low phase of new_div/2.
                r_div <= r_pend_div;
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (!en[i]) begin
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (r_cnt == w_last) begin
                r_cnt <= '0;
                r_out <= ~r_out;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_out[i] = r_out;
    end

    assign clk_out_1 = w_out[0];
    assign clk_out_2 = w_out[1];
    assign clk_out_4 = w_out[2];

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_sequencer
//  Purpose  : Self-checking bench for clk_div_sequencer. Divided outputs are
//             compared every cycle against a closed-form phase model; done /
//             err pulses are checked against a scoreboard of expected events
//             with the exact cycle each one must appear in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_sequencer;
    localparam int CNT_W = 16;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [2:0] en;
    logic       clk_out_1;
    logic       clk_out_2;
    logic       clk_out_4;

    clk_div_sequencer_if #(.CNT_W(CNT_W)) cfg ();

    clk_div_sequencer #(
        .CNT_W        (CNT_W),
        .DEFAULT_DIV_1(2),
        .DEFAULT_DIV_2(4),
        .DEFAULT_DIV_3(8)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .cfg      (cfg),
        .clk_out_1(clk_out_1),
        .clk_out_2(clk_out_2),
        .clk_out_4(clk_out_4)
    );

    always #5 clk_in = ~clk_in;

    // Edge counter: after the n-th rising edge, cyc == n.
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Phase model: after edge ref_e[i] channel i sat at counter 0 / output 0,
    // so after edge c its output is ((c - ref_e) / half) odd.
    int         ref_e [3];
    int         ref_h [3];
    logic [2:0] ref_on = 3'b000;
    logic [2:0] chk    = 3'b000;
    logic       mon_on = 1'b0;

    typedef struct {
        logic is_done;
        int   cyc;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First edge >= a+1 at which channel ch performs a falling toggle.
    function automatic int next_fall(input int ch, input int a);
        int p;
        int r;
        if (!ref_on[ch]) return a + 1;
        p = 2 * ref_h[ch];
        r = (a + 1 - ref_e[ch]) % p;
        return (r == 0) ? a + 1 : a + 1 + p - r;
    endfunction

    // Waveform monitor
    always @(negedge clk_in) begin
        logic [2:0] x;
        logic [2:0] o;
        if (chk != 3'b000) begin
            for (int i = 0; i < 3; i++)
                x[i] = ref_on[i] && ((((cyc - ref_e[i]) / ref_h[i]) % 2) == 1);
            o = {clk_out_4, clk_out_2, clk_out_1};
            n_vec++;
            assert ((o & chk) === (x & chk)) else begin
                n_err++;
                $error("FAIL wave cyc=%0d observed=%b expected=%b mask=%b", cyc, o, x, chk);
            end
        end
    end

    // Scoreboard monitor for done / err pulses
    always @(negedge clk_in) begin
        exp_t e;
        if (mon_on && (cfg.cfg_done || cfg.cfg_err)) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected cyc=%0d observed done=%b err=%b expected no event",
                       cyc, cfg.cfg_done, cfg.cfg_err);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                assert ({cfg.cfg_done, cfg.cfg_err, cyc} === {e.is_done, !e.is_done, e.cyc}) else begin
                    n_err++;
                    $error("FAIL sb_event observed done=%b err=%b cyc=%0d expected done=%b err=%b cyc=%0d",
                           cfg.cfg_done, cfg.cfg_err, cyc, e.is_done, !e.is_done, e.cyc);
                end
            end
        end
    end

    // One complete request; ok says whether the bench expects acceptance.
    task automatic send(input logic [1:0] s, input logic [15:0] d, input logic ok);
        int a;
        int b;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_sel   = s;
        cfg.cfg_div   = d;
        a = cyc + 1;
        if (ok) begin
            b = next_fall(int'(s), a);
            sb.push_back('{1'b1, b});
        end else begin
            b = a;
            sb.push_back('{1'b0, a});
        end
        step();
        cfg.cfg_valid = 1'b0;
        if (ok) begin
            check("busy_wait", cfg.busy, 1);
            check("ready_wait", cfg.cfg_ready, 0);
            while (cyc < b) step();
            ref_e[s] = b;
            ref_h[s] = int'(d) / 2;
            step();
            check("ready_after_done", cfg.cfg_ready, 1);
            check("busy_after_done", cfg.busy, 0);
        end else begin
            check("ready_err", cfg.cfg_ready, 1);
            check("busy_err", cfg.busy, 0);
            step();
        end
    endtask

    initial begin
        int guard;
        int a1;
        int b1;
        int a2;
        int b2;

        reset = 1'b1;
        en    = 3'b000;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_sel   = 2'd0;
        cfg.cfg_div   = '0;
        step();
        step();

        // Reset state
        check("rst_out", {29'd0, clk_out_4, clk_out_2, clk_out_1}, 0);
        check("rst_ready", cfg.cfg_ready, 1);
        check("rst_busy", cfg.busy, 0);
        check("rst_done_err", {cfg.cfg_done, cfg.cfg_err}, 0);

        // Release with all channels enabled: periods 2 / 4 / 8
        reset = 1'b0;
        en    = 3'b111;
        for (int i = 0; i < 3; i++) ref_e[i] = cyc;
        ref_h[0] = 1; ref_h[1] = 2; ref_h[2] = 4;
        ref_on = 3'b111;
        chk    = 3'b111;
        mon_on = 1'b1;
        repeat (24) step();

        // Channel 1 -> div 10, requested while clk_out_2 is high
        guard = 0;
        while (!clk_out_2 && guard < 16) begin
            step();
            guard++;
        end
        check("ch1_high_before_req", clk_out_2, 1);
        send(2'd1, 16'd10, 1'b1);
        repeat (30) step();

        // Illegal requests: odd factor, zero factor, channel 3
        send(2'd1, 16'd7, 1'b0);
        send(2'd1, 16'd0, 1'b0);
        send(2'd3, 16'd4, 1'b0);
        repeat (10) step();

        // Disabled channel 2 -> div 16 completes at minimum latency
        chk[2] = 1'b0;
        en = 3'b011;
        step();
        ref_on[2] = 1'b0;
        chk[2]    = 1'b1;
        send(2'd2, 16'd16, 1'b1);
        repeat (5) step();
        en = 3'b111;
        ref_e[2]  = cyc;
        ref_on[2] = 1'b1;
        repeat (40) step();

        // Reset one cycle into WAIT_EDGE discards the pending request
        cfg.cfg_valid = 1'b1;
        cfg.cfg_sel   = 2'd0;
        cfg.cfg_div   = 16'd6;
        step();
        cfg.cfg_valid = 1'b0;
        check("busy_before_rst", cfg.busy, 1);
        reset = 1'b1;
        chk   = 3'b000;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) ref_e[i] = cyc;
        ref_h[0] = 1; ref_h[1] = 2; ref_h[2] = 4;
        chk = 3'b111;
        check("ready_after_rst", cfg.cfg_ready, 1);
        check("busy_after_rst", cfg.busy, 0);
        repeat (20) step();

        // Second request held valid while the first is in flight
        cfg.cfg_valid = 1'b1;
        cfg.cfg_sel   = 2'd1;
        cfg.cfg_div   = 16'd12;
        a1 = cyc + 1;
        b1 = next_fall(1, a1);
        sb.push_back('{1'b1, b1});
        step();
        cfg.cfg_sel = 2'd0;
        cfg.cfg_div = 16'd4;
        a2 = b1 + 2;
        b2 = next_fall(0, a2);
        sb.push_back('{1'b1, b2});
        check("ready_held_off", cfg.cfg_ready, 0);
        while (cyc < b1) step();
        ref_e[1] = b1;
        ref_h[1] = 6;
        while (cyc < a2) step();
        cfg.cfg_valid = 1'b0;
        while (cyc < b2) step();
        ref_e[0] = b2;
        ref_h[0] = 2;
        step();
        check("ready_final", cfg.cfg_ready, 1);
        repeat (30) step();

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
